// File: rtl/fp_sgnj_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_sgnj_pipe
//  Description : Pipelined multi-lane floating-point sign injection unit
//                (FSGNJ / FSGNJN / FSGNJX) for single, double and half
//                precision. Narrow operands are NaN-box checked on entry and
//                narrow results are NaN-boxed on exit (NANBOX=1) or zero
//                filled (NANBOX=0). Results travel through a STAGES-deep
//                register pipeline with a valid/ready handshake, global
//                stall and synchronous flush.
//
//  Ports
//    clk                     : clock, rising edge
//    rst                     : asynchronous active-high reset
//    fp_sgnj_pipe_i_flush    : drop every in-flight operation at next edge
//    fp_sgnj_pipe_i_valid    : input operation valid
//    fp_sgnj_pipe_o_ready    : an operation can be accepted this cycle
//    fp_sgnj_pipe_i_data1    : magnitude source, lane k at [64k+63:64k]
//    fp_sgnj_pipe_i_data2    : sign source, same layout
//    fp_sgnj_pipe_i_fmt      : 0 single, 1 double, 2 half, 3 illegal
//    fp_sgnj_pipe_i_rm       : 0 SGNJ, 1 SGNJN, 2 SGNJX, others illegal
//    fp_sgnj_pipe_i_mask     : per-lane enable (disabled lanes read 0)
//    fp_sgnj_pipe_i_tag      : opaque tag travelling with the operation
//    fp_sgnj_pipe_o_valid    : result valid
//    fp_sgnj_pipe_i_ready    : downstream takes the result this cycle
//    fp_sgnj_pipe_o_result   : result lanes
//    fp_sgnj_pipe_o_tag      : tag of the presented result
//    fp_sgnj_pipe_o_illegal  : fmt or rm of the presented result was illegal
//
//  Parameters
//    LANES  : number of 64-bit lanes
//    STAGES : pipeline depth / latency, legal range 1..4
//    TAG_W  : tag width
//    NANBOX : 1 = NaN-box check and boxing, 0 = zero fill, no check
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_sgnj_pipe #(
    parameter int LANES  = 2,
    parameter int STAGES = 2,
    parameter int TAG_W  = 8,
    parameter int NANBOX = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fp_sgnj_pipe_i_flush,
    input  logic                  fp_sgnj_pipe_i_valid,
    output logic                  fp_sgnj_pipe_o_ready,
    input  logic [LANES*64-1:0]   fp_sgnj_pipe_i_data1,
    input  logic [LANES*64-1:0]   fp_sgnj_pipe_i_data2,
    input  logic [1:0]            fp_sgnj_pipe_i_fmt,
    input  logic [2:0]            fp_sgnj_pipe_i_rm,
    input  logic [LANES-1:0]      fp_sgnj_pipe_i_mask,
    input  logic [TAG_W-1:0]      fp_sgnj_pipe_i_tag,
    output logic                  fp_sgnj_pipe_o_valid,
    input  logic                  fp_sgnj_pipe_i_ready,
    output logic [LANES*64-1:0]   fp_sgnj_pipe_o_result,
    output logic [TAG_W-1:0]      fp_sgnj_pipe_o_tag,
    output logic                  fp_sgnj_pipe_o_illegal
);

    // ------------------------------------------------------------------
    // Encodings and constants
    // ------------------------------------------------------------------
    localparam logic [1:0]  c_FMT_S    = 2'd0;
    localparam logic [1:0]  c_FMT_D    = 2'd1;
    localparam logic [1:0]  c_FMT_H    = 2'd2;

    localparam logic [2:0]  c_RM_SGNJ  = 3'd0;
    localparam logic [2:0]  c_RM_SGNJN = 3'd1;
    localparam logic [2:0]  c_RM_SGNJX = 3'd2;

    localparam logic [31:0] c_QNAN_S   = 32'h7FC0_0000;
    localparam logic [15:0] c_QNAN_H   = 16'h7E00;

    // Fill pattern for the bits above a narrow result.
    localparam logic [63:0] c_FILL     = (NANBOX != 0) ? {64{1'b1}} : 64'h0;

    // ------------------------------------------------------------------
    // Replace an improperly boxed narrow operand by the canonical NaN of
    // its format. Upper bits of the returned value are don't-care for the
    // injection step, which only looks at the low format bits.
    // ------------------------------------------------------------------
    function automatic logic [63:0] unbox(
        input logic [63:0] op,
        input logic [1:0]  fmt
    );
        logic [63:0] v;
        v = op;
        if (NANBOX != 0) begin
            if ((fmt == c_FMT_S) && !(&op[63:32])) begin
                v = {32'h0, c_QNAN_S};
            end else if ((fmt == c_FMT_H) && !(&op[63:16])) begin
                v = {48'h0, c_QNAN_H};
            end
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Sign injection on already-unboxed operands. Illegal fmt/rm return
    // zero so that the caller only has to gate by lane mask.
    // ------------------------------------------------------------------
    function automatic logic [63:0] inject(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [1:0]  fmt,
        input logic [2:0]  rm
    );
        logic        s1;
        logic        s2;
        logic        s;
        logic [63:0] r;

        case (fmt)
            c_FMT_S: begin s1 = a[31]; s2 = b[31]; end
            c_FMT_D: begin s1 = a[63]; s2 = b[63]; end
            c_FMT_H: begin s1 = a[15]; s2 = b[15]; end
            default: begin s1 = 1'b0;  s2 = 1'b0;  end
        endcase

        case (rm)
            c_RM_SGNJ:  s = s2;
            c_RM_SGNJN: s = ~s2;
            c_RM_SGNJX: s = s1 ^ s2;
            default:    s = 1'b0;
        endcase

        case (fmt)
            c_FMT_S: r = {c_FILL[63:32], s, a[30:0]};
            c_FMT_D: r = {s, a[62:0]};
            c_FMT_H: r = {c_FILL[63:16], s, a[14:0]};
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Combinational front end, registered into stage 0
    // ------------------------------------------------------------------
    logic                w_fmt_ok;
    logic                w_rm_ok;
    logic                w_illegal;
    logic [LANES*64-1:0] w_result;

    assign w_fmt_ok  = (fp_sgnj_pipe_i_fmt != 2'd3);
    assign w_rm_ok   = (fp_sgnj_pipe_i_rm <= c_RM_SGNJX);
    assign w_illegal = ~(w_fmt_ok & w_rm_ok);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [63:0] w_op1;
        logic [63:0] w_op2;

        // The box check applies to each operand independently.
        assign w_op1 = unbox(fp_sgnj_pipe_i_data1[64*k +: 64], fp_sgnj_pipe_i_fmt);
        assign w_op2 = unbox(fp_sgnj_pipe_i_data2[64*k +: 64], fp_sgnj_pipe_i_fmt);

        assign w_result[64*k +: 64] = (fp_sgnj_pipe_i_mask[k] && !w_illegal)
                                    ? inject(w_op1, w_op2, fp_sgnj_pipe_i_fmt, fp_sgnj_pipe_i_rm)
                                    : 64'h0;
    end

    // ------------------------------------------------------------------
    // Pipeline: all stages move together whenever the last stage is empty
    // or being consumed. Bubbles are intentionally kept in place so the
    // latency of every operation is exactly STAGES cycles when unstalled.
    // ------------------------------------------------------------------
    logic [STAGES-1:0]   r_v;
    logic [LANES*64-1:0] r_data [STAGES];
    logic [TAG_W-1:0]    r_tag  [STAGES];
    logic                r_ill  [STAGES];

    logic                w_adv;
    logic                w_accept;

    assign w_adv    = ~r_v[STAGES-1] | fp_sgnj_pipe_i_ready;
    assign w_accept = fp_sgnj_pipe_i_valid & fp_sgnj_pipe_o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
                r_ill[i]  <= 1'b0;
            end
        end else begin
            // Flush wins over both accept and stall.
            if (fp_sgnj_pipe_i_flush) begin
                r_v <= '0;
            end else if (w_adv) begin
                r_v[0] <= w_accept;
                for (int i = 1; i < STAGES; i++) begin
                    r_v[i] <= r_v[i-1];
                end
            end

            // Payload follows the valid bits; its content is irrelevant
            // wherever the matching valid bit is clear.
            if (w_adv) begin
                r_data[0] <= w_result;
                r_tag[0]  <= fp_sgnj_pipe_i_tag;
                r_ill[0]  <= w_illegal;
                for (int i = 1; i < STAGES; i++) begin
                    r_data[i] <= r_data[i-1];
                    r_tag[i]  <= r_tag[i-1];
                    r_ill[i]  <= r_ill[i-1];
                end
            end
        end
    end

    assign fp_sgnj_pipe_o_ready   = w_adv & ~fp_sgnj_pipe_i_flush;
    assign fp_sgnj_pipe_o_valid   = r_v[STAGES-1];
    assign fp_sgnj_pipe_o_result  = r_data[STAGES-1];
    assign fp_sgnj_pipe_o_tag     = r_tag[STAGES-1];
    assign fp_sgnj_pipe_o_illegal = r_ill[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_fp_sgnj_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_sgnj_pipe
//  Description : Self-checking bench for fp_sgnj_pipe. Directed vectors,
//                back-to-back streaming with a stall, randomized streaming
//                against a behavioural model, flush and mid-stall reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_sgnj_pipe;

    localparam int LANES  = 2;
    localparam int STAGES = 2;
    localparam int TAG_W  = 8;
    localparam int NANBOX = 1;
    localparam int DW     = LANES * 64;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             i_valid;
    logic             o_ready;
    logic [DW-1:0]    d1;
    logic [DW-1:0]    d2;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic [LANES-1:0] mask;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [DW-1:0]    o_result;
    logic [TAG_W-1:0] o_tag;
    logic             o_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    fp_sgnj_pipe #(
        .LANES  (LANES),
        .STAGES (STAGES),
        .TAG_W  (TAG_W),
        .NANBOX (NANBOX)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .fp_sgnj_pipe_i_flush   (flush),
        .fp_sgnj_pipe_i_valid   (i_valid),
        .fp_sgnj_pipe_o_ready   (o_ready),
        .fp_sgnj_pipe_i_data1   (d1),
        .fp_sgnj_pipe_i_data2   (d2),
        .fp_sgnj_pipe_i_fmt     (fmt),
        .fp_sgnj_pipe_i_rm      (rm),
        .fp_sgnj_pipe_i_mask    (mask),
        .fp_sgnj_pipe_i_tag     (i_tag),
        .fp_sgnj_pipe_o_valid   (o_valid),
        .fp_sgnj_pipe_i_ready   (i_ready),
        .fp_sgnj_pipe_o_result  (o_result),
        .fp_sgnj_pipe_o_tag     (o_tag),
        .fp_sgnj_pipe_o_illegal (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: format width w, sign at bit w-1, box = all bits
    // above w set.
    // ------------------------------------------------------------------
    function automatic logic [63:0] ref_lane(input logic [63:0] a, input logic [63:0] b,
                                             input int f, input int r);
        int          w;
        logic [63:0] low;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] res;
        logic        sa;
        logic        sb;
        logic        s;
        case (f)
            0:       w = 32;
            1:       w = 64;
            2:       w = 16;
            default: return 64'h0;
        endcase
        if (r > 2) return 64'h0;
        low = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        ua  = a & low;
        ub  = b & low;
        if (NANBOX != 0 && w < 64) begin
            if ((a | low) != {64{1'b1}}) ua = (w == 32) ? 64'h7FC0_0000 : 64'h7E00;
            if ((b | low) != {64{1'b1}}) ub = (w == 32) ? 64'h7FC0_0000 : 64'h7E00;
        end
        sa = ua[w-1];
        sb = ub[w-1];
        s  = (r == 0) ? sb : (r == 1) ? !sb : (sa ^ sb);
        res = (ua & (low >> 1)) | (s ? (64'd1 << (w - 1)) : 64'h0);
        if (NANBOX != 0 && w < 64) res = res | ~low;
        return res;
    endfunction

    function automatic logic [DW-1:0] ref_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input int f, input int r, input logic [LANES-1:0] m);
        logic [DW-1:0] res;
        res = '0;
        for (int k = 0; k < LANES; k++)
            res[64*k +: 64] = m[k] ? ref_lane(a[64*k +: 64], b[64*k +: 64], f, r) : 64'h0;
        return res;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom % 4)
            0:       v[63:16] = '1;
            1, 2:    v[63:32] = '1;
            default: ;
        endcase
        return v;
    endfunction

    typedef struct {
        logic [DW-1:0]    res;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    exp_t sb_q[$];

    task automatic idle_inputs();
        i_valid = 1'b0;
        flush   = 1'b0;
        i_ready = 1'b1;
        d1      = '0;
        d2      = '0;
        fmt     = 2'd0;
        rm      = 3'd0;
        mask    = '1;
        i_tag   = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #1;
        n_checks++; if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++; if (o_result !== '0)    begin n_fail++; $display("FAIL reset_result: got %h want 0", o_result); end
        n_checks++; if (o_tag !== '0)       begin n_fail++; $display("FAIL reset_tag: got %h want 0", o_tag); end
        n_checks++; if (o_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", o_illegal); end
        n_checks++; if (o_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_directed();
        logic [63:0]      a0 [6];
        logic [63:0]      b0 [6];
        int               fv [6];
        int               rv [6];
        logic [LANES-1:0] mv [6];
        logic [63:0]      e0 [6];
        logic             ev [6];
        logic [DW-1:0]    exp_res;
        a0[0] = 64'hFFFFFFFF3F800000; b0[0] = 64'hFFFFFFFF3F800000; fv[0] = 0; rv[0] = 1; mv[0] = 2'b11; e0[0] = 64'hFFFFFFFFBF800000; ev[0] = 0;
        a0[1] = 64'h000000003F800000; b0[1] = 64'hFFFFFFFF80000000; fv[1] = 0; rv[1] = 0; mv[1] = 2'b11; e0[1] = 64'hFFFFFFFFFFC00000; ev[1] = 0;
        a0[2] = 64'hC000000000000000; b0[2] = 64'h8000000000000000; fv[2] = 1; rv[2] = 2; mv[2] = 2'b01; e0[2] = 64'h4000000000000000; ev[2] = 0;
        a0[3] = 64'hFFFFFFFFFFFF3C00; b0[3] = 64'hFFFFFFFFFFFF8000; fv[3] = 2; rv[3] = 0; mv[3] = 2'b11; e0[3] = 64'hFFFFFFFFFFFFBC00; ev[3] = 0;
        a0[4] = 64'hFFFFFFFFFFFF3C00; b0[4] = 64'hFFFFFFFFFFFF8000; fv[4] = 2; rv[4] = 3; mv[4] = 2'b11; e0[4] = 64'h0;                ev[4] = 1;
        a0[5] = 64'hFFFFFFFF3F800000; b0[5] = 64'hFFFFFFFF80000000; fv[5] = 3; rv[5] = 0; mv[5] = 2'b11; e0[5] = 64'h0;                ev[5] = 1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            d1 = {rand_operand(), a0[t]};
            d2 = {rand_operand(), b0[t]};
            fmt = fv[t][1:0]; rm = rv[t][2:0]; mask = mv[t];
            i_tag = TAG_W'(8'hA0 + t); i_valid = 1'b1; i_ready = 1'b1;
            exp_res = ref_op(d1, d2, fv[t], rv[t], mv[t]);
            @(negedge clk);
            i_valid = 1'b0;
            for (int c = 1; c < STAGES; c++) begin
                #1;
                n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid: got %b want 0", t, o_valid); end
                @(negedge clk);
            end
            #1;
            n_checks++; if (o_valid !== 1'b1)          begin n_fail++; $display("FAIL dir%0d_valid: got %b want 1", t, o_valid); end
            n_checks++; if (o_result[63:0] !== e0[t])  begin n_fail++; $display("FAIL dir%0d_lane0: got %h want %h", t, o_result[63:0], e0[t]); end
            n_checks++; if (o_result !== exp_res)      begin n_fail++; $display("FAIL dir%0d_result: got %h want %h", t, o_result, exp_res); end
            n_checks++; if (o_illegal !== ev[t])       begin n_fail++; $display("FAIL dir%0d_illegal: got %b want %b", t, o_illegal, ev[t]); end
            n_checks++; if (o_tag !== TAG_W'(8'hA0 + t)) begin n_fail++; $display("FAIL dir%0d_tag: got %h want %h", t, o_tag, TAG_W'(8'hA0 + t)); end
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Streaming engine: rnd=0 sends tags 1..n back to back with i_ready
    // low for cycles 4..6; rnd=1 randomizes valid, ready and operands.
    // ------------------------------------------------------------------
    task automatic stream_ops(input int n_ops, input bit rnd, output int got, output int stall_full);
        int               sent;
        int               cyc;
        int               f;
        int               r;
        bit               prev_hold;
        logic [DW-1:0]    prev_res;
        logic [TAG_W-1:0] prev_tag;
        logic             prev_ill;
        exp_t             e;
        bit               exp_ready;
        sb_q.delete();
        sent = 0; got = 0; cyc = 0; stall_full = 0; prev_hold = 0;
        prev_res = '0; prev_tag = '0; prev_ill = 1'b0;
        while ((sent < n_ops || got < sent) && cyc < n_ops * 20 + 50) begin
            @(negedge clk);
            cyc++;
            if (sent < n_ops) begin
                i_valid = rnd ? (($urandom % 4) != 0) : 1'b1;
                f = rnd ? int'($urandom_range(0, 3)) : (sent % 3);
                r = rnd ? ((($urandom % 8) < 6) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 7))) : (sent % 3);
                for (int k = 0; k < LANES; k++) begin
                    d1[64*k +: 64] = rand_operand();
                    d2[64*k +: 64] = rand_operand();
                end
                fmt   = f[1:0];
                rm    = r[2:0];
                mask  = rnd ? LANES'($urandom) : '1;
                i_tag = rnd ? TAG_W'($urandom) : TAG_W'(sent + 1);
            end else begin
                i_valid = 1'b0;
            end
            i_ready = rnd ? (($urandom % 4) != 0) : !(cyc >= 4 && cyc <= 6);
            #1;
            if (prev_hold) begin
                n_checks++;
                if (o_valid !== 1'b1 || o_result !== prev_res || o_tag !== prev_tag || o_illegal !== prev_ill) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%b tag=%h res=%h want v=1 tag=%h res=%h", o_valid, o_tag, o_result, prev_tag, prev_res);
                end
            end
            exp_ready = !(o_valid === 1'b1 && i_ready == 1'b0);
            n_checks++;
            if (o_ready !== exp_ready) begin n_fail++; $display("FAIL stream_ready: got %b want %b", o_ready, exp_ready); end
            if (o_valid === 1'b1 && i_ready == 1'b0) stall_full++;
            if (o_valid === 1'b1 && i_ready == 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: got tag %h want no output", o_tag);
                end else begin
                    e = sb_q.pop_front();
                    if (o_result !== e.res || o_tag !== e.tag || o_illegal !== e.ill) begin
                        n_fail++;
                        $display("FAIL stream_data: got tag=%h ill=%b res=%h want tag=%h ill=%b res=%h", o_tag, o_illegal, o_result, e.tag, e.ill, e.res);
                    end
                end
                got++;
            end
            if (i_valid && o_ready === 1'b1) begin
                e.res = ref_op(d1, d2, int'(fmt), int'(rm), mask);
                e.tag = i_tag;
                e.ill = (fmt == 2'd3) || (rm > 3'd2);
                sb_q.push_back(e);
                sent++;
            end
            prev_hold = (o_valid === 1'b1) && !i_ready;
            prev_res = o_result; prev_tag = o_tag; prev_ill = o_illegal;
        end
        n_checks++;
        if (sent != n_ops || got != n_ops || sb_q.size() != 0) begin
            n_fail++; $display("FAIL stream_count: got sent=%0d recv=%0d want %0d each", sent, got, n_ops);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int got;
        int stall_full;
        stream_ops(8, 1'b0, got, stall_full);
        n_checks++;
        if (stall_full != 3) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 3", stall_full); end
        n_checks++;
        if (got != 8) begin n_fail++; $display("FAIL b2b_delivered: got %0d want 8", got); end
    endtask

    task automatic test_random();
        int got;
        int stall_full;
        stream_ops(60, 1'b1, got, stall_full);
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        int seen;
        @(negedge clk);
        d1 = {2{64'hFFFFFFFF3F800000}}; d2 = '0; fmt = 2'd0; rm = 3'd0; mask = '1;
        i_tag = 8'h11; i_valid = 1'b1; i_ready = 1'b0;
        @(negedge clk);
        i_tag = 8'h12;
        @(negedge clk);
        flush = 1'b1; i_tag = 8'h13; i_valid = 1'b1; i_ready = 1'b0;
        #1;
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", o_ready); end
        @(negedge clk);
        flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 2 * STAGES + 2; c++) begin
            #1;
            if (o_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_reset_mid_stall();
        int waited;
        @(negedge clk);
        d1 = {2{64'hC000000000000000}}; d2 = {2{64'h8000000000000000}};
        fmt = 2'd1; rm = 3'd2; mask = '1; i_tag = 8'h5A; i_valid = 1'b1; i_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        waited = 0;
        #1;
        while (o_valid !== 1'b1 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rststall_fill: got %b want 1", o_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL rststall_valid: got %b want 0", o_valid); end
        n_checks++; if (o_result !== '0)    begin n_fail++; $display("FAIL rststall_result: got %h want 0", o_result); end
        n_checks++; if (o_tag !== '0)       begin n_fail++; $display("FAIL rststall_tag: got %h want 0", o_tag); end
        n_checks++; if (o_illegal !== 1'b0) begin n_fail++; $display("FAIL rststall_illegal: got %b want 0", o_illegal); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rststall_ready: got %b want 1", o_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rststall_after: got %b want 0", o_valid); end
        i_ready = 1'b1;
    endtask

    // ------------------------------------------------------------------
    initial begin
        int got;
        int stall_full;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid_stall();
        stream_ops(6, 1'b1, got, stall_full);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_sgnj_pipe.md
# fp_sgnj_pipe

Pipelined, multi-lane floating-point sign-injection unit (FSGNJ/FSGNJN/FSGNJX) for the float execute stage. It supersedes the single-lane combinational sign-injector. It adds half precision, per-lane masking and RISC-V NaN-boxing of narrow operands and results. Operations pass through a configurable register pipeline with a valid/ready handshake and a global stall.

## Interface
- LANES, default 2: number of independent 64-bit lanes.
- STAGES, default 2: pipeline depth, legal 1..4; equals latency in cycles.
- TAG_W, default 8: width of opaque tag carried alongside each operation.
- NANBOX, default 1: 1 enables NaN-box checking on inputs and boxing on outputs; 0 zero-fills upper bits and skips checks.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fp_sgnj_pipe_i_flush  in  1  synchronous pipeline flush.
- fp_sgnj_pipe_i_valid  in  1  input operation valid.
- fp_sgnj_pipe_o_ready  out  1  unit can accept an operation this cycle.
- fp_sgnj_pipe_i_data1  in  LANES*64  magnitude source, lane k at [64k+63:64k].
- fp_sgnj_pipe_i_data2  in  LANES*64  sign source.
- fp_sgnj_pipe_i_fmt  in  2  0 single, 1 double, 2 half, 3 illegal.
- fp_sgnj_pipe_i_rm  in  3  0 SGNJ, 1 SGNJN, 2 SGNJX, others illegal.
- fp_sgnj_pipe_i_mask  in  LANES  per-lane enable.
- fp_sgnj_pipe_i_tag  in  TAG_W  tag.
- fp_sgnj_pipe_o_valid  out  1  result valid.
- fp_sgnj_pipe_i_ready  in  1  downstream accepts result.
- fp_sgnj_pipe_o_result  out  LANES*64  result lanes.
- fp_sgnj_pipe_o_tag  out  TAG_W  tag of the result.
- fp_sgnj_pipe_o_illegal  out  1  fmt or rm illegal for this result.

## Operation
- Sign bit position by format: single uses bit 31, double bit 63, half bit 15. Magnitude is all bits below the sign within the format width.
- Sign by rm:
  - SGNJ: sign = s2.
  - SGNJN: sign = ~s2.
  - SGNJX: sign = s1 ^ s2.
- Result lane = {sign, magnitude of data1}, placed in the low format bits.
- Upper bits (63:32 single, 63:16 half):
  - NANBOX=1: all ones.
  - NANBOX=0: all zeros.
  - Double has no upper field.
- Input box check (NANBOX=1, single/half only): an operand whose upper bits are not all ones is replaced by the canonical NaN before injection. Canonical NaN is 0x7FC00000 for single and 0x7E00 for half. The check is per operand, per lane.
- Masked-off lane (mask[k]=0): result lane is 64'h0.
- Illegal fmt/rm: all result lanes are 0 and o_illegal=1. The operation still flows through the pipeline and is handshaked normally.
- Computation is combinational on input and registered into stage 0. Later stages only delay data.

## Timing
- Stage valid bits v[0..STAGES-1]. Define adv = ~v[STAGES-1] | i_ready.
  - o_ready = adv & ~i_flush.
  - o_valid = v[STAGES-1].
- When adv=1, all stages shift together each edge:
  - v[0] <= i_valid & o_ready.
  - Data, tag and illegal shift alongside the valid bits.
  - Bubbles are not collapsed.
- When adv=0, all stages hold. Outputs stay stable while o_valid=1 and i_ready=0.
- Latency: an operation accepted at edge N appears with o_valid=1 after edge N+STAGES-1, i.e. for STAGES=1 it is valid the cycle after acceptance. This assumes no stall.
- Throughput: 1 operation per cycle while i_ready=1.
- Flush:
  - i_flush=1 clears every v[] at the next edge.
  - Flush beats accept and stall; the input is not accepted that cycle.
  - Data registers need not clear.
- Reset (async assert, any time including mid-stall):
  - All v[]=0, o_valid=0, o_result=0, o_tag=0, o_illegal=0.
  - o_ready=1 once rst deasserts, provided i_flush=0.
- Simultaneous i_valid and output consumption with a full pipe: accepted, because adv=1.

## Test plan
- Single, SGNJN, NANBOX=1, lane0 data1=0xFFFFFFFF3F800000, data2=0xFFFFFFFF3F800000 -> after STAGES cycles lane0 = 0xFFFFFFFFBF800000, o_illegal=0.
- Single SGNJ with unboxed data1=0x000000003F800000, data2=0xFFFFFFFF80000000 -> lane0 = 0xFFFFFFFFFFC00000, from the canonical NaN with sign set.
- Double SGNJX, data1=0xC000000000000000, data2=0x8000000000000000, mask=2'b01 -> lane0=0x4000000000000000, lane1=0.
- Half SGNJ, data1=0xFFFFFFFFFFFF3C00, data2=0xFFFFFFFFFFFF8000 -> 0xFFFFFFFFFFFFBC00. Also rm=3 -> all lanes 0 and o_illegal=1.
- Back-to-back 8 ops with tags 1..8, i_ready low for 3 cycles mid-stream -> outputs held stable, o_ready=0 while the pipe is full, all tags delivered in order with none lost or duplicated.
- Assert i_flush with 2 ops in flight, and separately assert rst mid-stall -> no o_valid for flushed ops; after reset all outputs are 0 and o_ready=1.
